// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc decode->execute interface: field widths, ALU operand
// mux encodings and the packed control bundle carried by the pipeline register.
package jzjpcc_pkg;

    localparam int XLEN       = 32;
    localparam int ALU_OP_W   = 3;
    localparam int ALU_MUX_W  = 2;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [ALU_MUX_W-1:0] {
        ALU_MUX_RS1_RS2 = 2'd0,
        ALU_MUX_RS1_IMM = 2'd1,
        ALU_MUX_PC_IMM  = 2'd2,
        ALU_MUX_PC_4    = 2'd3
    } alu_mux_mode_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  alu_mod;
        alu_mux_mode_e         alu_mux;
        logic                  rd_we;
        logic                  mem_read;
    } de_ctrl_t;

    localparam de_ctrl_t BUBBLE = '0;

    // A slot without a real instruction must never write rd or start a load.
    function automatic de_ctrl_t gate_invalid(input de_ctrl_t c);
        de_ctrl_t g;
        g = c;
        if (!c.valid) begin
            g.rd_we    = 1'b0;
            g.mem_read = 1'b0;
        end else begin
            g = c;
        end
        return g;
    endfunction

endpackage

// File: rtl/jzjpcc_hazard_detect.sv
// Load-use interlock detector: flags a decode instruction that reads the
// destination of a load still sitting in execute.
module jzjpcc_hazard_detect
    import jzjpcc_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_rd_we,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
    output logic                  hazard
);

    // x0 is never a real producer, so a load into it cannot interlock.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_mem_read && ex_rd_we &&
            (ex_rd_addr != {REG_ADDR_W{1'b0}}) && dec_valid) begin
            hazard = (dec_rs1_addr == ex_rd_addr) || (dec_rs2_addr == ex_rd_addr);
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/jzjpcc_decode_execute_register.sv
// Decode->execute pipeline register with stall hold, flush and load-use bubbles.
// Optional bubble counter output enabled by defining JZJPCC_BUBBLE_COUNTER_EN.
module jzjpcc_decode_execute_register
    import jzjpcc_pkg::*;
#(
    parameter int PC_MAX_B = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_decode,
    input  logic [XLEN-1:0]       immediate_decode,
    input  logic [XLEN-1:0]       rs1_decode,
    input  logic [XLEN-1:0]       rs2_decode,
    input  logic [REG_ADDR_W-1:0] rs1Addr_decode,
    input  logic [REG_ADDR_W-1:0] rs2Addr_decode,
    input  logic [PC_MAX_B:2]     currentPC_decode,
    input  logic [REG_ADDR_W-1:0] rdAddr_decode,
    input  logic [ALU_OP_W-1:0]   aluOperation_decode,
    input  logic                  aluMod_decode,
    input  logic [ALU_MUX_W-1:0]  aluMuxMode_decode,
    input  logic                  rdWriteEnable_decode,
    input  logic                  memRead_decode,
    input  logic                  stall_in,
    input  logic                  flush_execute,
    output logic                  valid_execute,
    output logic [XLEN-1:0]       immediate_execute,
    output logic [XLEN-1:0]       rs1_execute,
    output logic [XLEN-1:0]       rs2_execute,
    output logic [PC_MAX_B:2]     currentPC_execute,
    output logic [REG_ADDR_W-1:0] rdAddr_execute,
    output logic [ALU_OP_W-1:0]   aluOperation_execute,
    output logic                  aluMod_execute,
    output logic [ALU_MUX_W-1:0]  aluMuxMode_execute,
    output logic                  rdWriteEnable_execute,
    output logic                  memRead_execute,
`ifdef JZJPCC_BUBBLE_COUNTER_EN
    output logic [31:0]           bubbleCount,
`endif
    output logic                  stall_decode
);

    de_ctrl_t            ctrl_d, ctrl_q, dec_ctrl_s;
    logic [XLEN-1:0]     imm_d, imm_q;
    logic [XLEN-1:0]     rs1_d, rs1_q;
    logic [XLEN-1:0]     rs2_d, rs2_q;
    logic [PC_MAX_B:2]   pc_d, pc_q;
    logic                hazard_s;
    logic                load_bubble_s;

    jzjpcc_hazard_detect u_hazard (
        .ex_valid     (ctrl_q.valid),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_rd_we     (ctrl_q.rd_we),
        .ex_rd_addr   (ctrl_q.rd_addr),
        .dec_valid    (valid_decode),
        .dec_rs1_addr (rs1Addr_decode),
        .dec_rs2_addr (rs2Addr_decode),
        .hazard       (hazard_s)
    );

    // Pack the incoming control fields, masking side effects of empty slots.
    always_comb begin
        dec_ctrl_s          = BUBBLE;
        dec_ctrl_s.valid    = valid_decode;
        dec_ctrl_s.rd_addr  = rdAddr_decode;
        dec_ctrl_s.alu_op   = aluOperation_decode;
        dec_ctrl_s.alu_mod  = aluMod_decode;
        dec_ctrl_s.alu_mux  = alu_mux_mode_e'(aluMuxMode_decode);
        dec_ctrl_s.rd_we    = rdWriteEnable_decode;
        dec_ctrl_s.mem_read = memRead_decode;
        dec_ctrl_s          = gate_invalid(dec_ctrl_s);
    end

    assign load_bubble_s = flush_execute | hazard_s;
    // A flush kills the decode instruction, so decode need not hold for the interlock.
    assign stall_decode  = stall_in | (hazard_s & ~flush_execute);

    // Next-state selection: stall hold beats flush, flush beats interlock, else load.
    always_comb begin
        ctrl_d = ctrl_q;
        imm_d  = imm_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        pc_d   = pc_q;
        if (stall_in) begin
            ctrl_d = ctrl_q;
            imm_d  = imm_q;
            rs1_d  = rs1_q;
            rs2_d  = rs2_q;
            pc_d   = pc_q;
        end else if (load_bubble_s) begin
            ctrl_d = BUBBLE;
            imm_d  = {XLEN{1'b0}};
            rs1_d  = {XLEN{1'b0}};
            rs2_d  = {XLEN{1'b0}};
            pc_d   = '0;
        end else begin
            ctrl_d = dec_ctrl_s;
            imm_d  = immediate_decode;
            rs1_d  = rs1_decode;
            rs2_d  = rs2_decode;
            pc_d   = currentPC_decode;
        end
    end

    // Pipeline register state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= BUBBLE;
            imm_q  <= {XLEN{1'b0}};
            rs1_q  <= {XLEN{1'b0}};
            rs2_q  <= {XLEN{1'b0}};
            pc_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            imm_q  <= imm_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            pc_q   <= pc_d;
        end
    end

    assign valid_execute         = ctrl_q.valid;
    assign immediate_execute     = imm_q;
    assign rs1_execute           = rs1_q;
    assign rs2_execute           = rs2_q;
    assign currentPC_execute     = pc_q;
    assign rdAddr_execute        = ctrl_q.rd_addr;
    assign aluOperation_execute  = ctrl_q.alu_op;
    assign aluMod_execute        = ctrl_q.alu_mod;
    assign aluMuxMode_execute    = ctrl_q.alu_mux;
    assign rdWriteEnable_execute = ctrl_q.rd_we;
    assign memRead_execute       = ctrl_q.mem_read;

`ifdef JZJPCC_BUBBLE_COUNTER_EN
    logic [31:0] bubble_count_d, bubble_count_q;

    // Count only edges that actually load a bubble; wraps naturally at 2^32.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (!stall_in && load_bubble_s) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end else begin
            bubble_count_d = bubble_count_q;
        end
    end

    // Bubble counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_count_q <= 32'd0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bubbleCount = bubble_count_q;
`endif

endmodule

// File: doc/jzjpcc_decode_execute_register.md
Name: jzjpcc_decode_execute_register

Overview:
- Producer side of the decode→execute interface: the pipeline register that drives every *_execute signal consumed by the execute stage.
- Captures decoded operands and control each cycle.
- Handles downstream stalls, branch flushes and load-use interlocks (bubble insertion).
- Sits between jzjpcc_decode and jzjpcc_execute in the 5-stage core.

Parameters:
- PC_MAX_B, 31, MSB index of the word-aligned PC field (PC bits [PC_MAX_B:2]).

Ports:
- clock  input  1  core clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- valid_decode  input  1  decode holds a real instruction
- immediate_decode  input  32  decoded immediate
- rs1_decode  input  32  register file read data 1
- rs2_decode  input  32  register file read data 2
- rs1Addr_decode  input  5  source register 1 index
- rs2Addr_decode  input  5  source register 2 index
- currentPC_decode  input  PC_MAX_B-1  PC of decode instruction
- rdAddr_decode  input  5  destination index
- aluOperation_decode  input  3  ALU funct3
- aluMod_decode  input  1  ALU modifier (sub/sra)
- aluMuxMode_decode  input  2  ALU operand mux select
- rdWriteEnable_decode  input  1  instruction writes rd
- memRead_decode  input  1  instruction is a load
- stall_in  input  1  downstream (memory stage) cannot accept
- flush_execute  input  1  branch/jump taken; kill decode instruction
- valid_execute  output  1  execute holds a real instruction
- immediate_execute, rs1_execute, rs2_execute  output  32 each  registered copies
- currentPC_execute  output  PC_MAX_B-1  registered PC
- rdAddr_execute  output  5  registered rd
- aluOperation_execute  output  3; aluMod_execute  output  1; aluMuxMode_execute  output  2
- rdWriteEnable_execute, memRead_execute  output  1 each
- stall_decode  output  1  combinational; fetch/decode must hold

Behaviour:
- Reset (reset=0, async): every output register = 0, including valid_execute, rdWriteEnable_execute and memRead_execute; stall_decode then follows its equation from cleared state.
- Latency: 1 cycle from *_decode to *_execute.
- hazard (combinational) = valid_execute & memRead_execute & rdWriteEnable_execute & (rdAddr_execute≠0) & valid_decode & ((rs1Addr_decode==rdAddr_execute) | (rs2Addr_decode==rdAddr_execute)).
- stall_decode = stall_in | (hazard & ~flush_execute).
- Per-edge priority, highest first:
  1. stall_in=1: hold all registers unchanged. A coincident flush_execute is not consumed; its source must keep it asserted until stall_in=0.
  2. flush_execute=1: load bubble.
  3. hazard=1: load bubble; decode holds its instruction, which re-presents next cycle and then passes (the load has left execute).
  4. Otherwise: load all *_decode fields; valid_execute=valid_decode.
- Bubble: all outputs 0 (valid, rdWriteEnable, memRead, rdAddr, ALU controls, data, PC).
- Input with valid_decode=0: loads normally but forces rdWriteEnable_execute=0 and memRead_execute=0.
- rd=x0 never causes a hazard.
- Back-to-back loads: the interlock fires at most one cycle per dependent instruction.

Optional Feature:
- Macro JZJPCC_BUBBLE_COUNTER_EN.
- Defined: adds output bubbleCount (32 bit). Resets to 0; increments by 1 on each edge that loads a bubble (flush or hazard, not during stall_in); wraps 0xFFFFFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package jzjpcc_pkg holds:
  - widths: ALU_OP_W=3, ALU_MUX_W=2, REG_ADDR_W=5
  - enum for aluMuxMode encodings
  - packed struct for the decode→execute control bundle
  - constant BUBBLE of that struct (all zero)
- One sub-module, jzjpcc_hazard_detect: pure combinational load-use comparator producing hazard.

Test Plan:
- Reset: hold reset=0 mid-stream with valid pipeline → all outputs 0 immediately (async); first edge after release loads decode inputs.
- Pass-through: decode addi x5 (imm=0x10, PC=0x40) → next cycle immediate_execute=0x10, rdAddr_execute=5, rdWriteEnable_execute=1, valid_execute=1.
- Load-use: lw x3 in execute (memRead=1, rd=3), decode add x4,x3,x1 → stall_decode=1; next edge bubble (valid_execute=0); following edge add loads; stall_decode=0.
- x0 load: lw x0 then add x1,x0,x0 → no stall; add enters execute next cycle.
- Flush vs stall: flush_execute=1 with stall_in=1 → registers hold. Drop stall_in with flush still high → bubble loaded and decode instruction discarded; with counter enabled, bubbleCount increments by exactly 1.
- Stall hold: stall_in=1 for 3 cycles with changing decode inputs → *_execute unchanged; stall_decode=1 all 3 cycles.
